// File: rtl/aes_defines.sv
// Shared AES constants plus the frame-transmitter state type and the
// final-block byte-enable helpers.
package aes_defines;

  localparam int AES_BLOCK_SIZE    = 128;
  localparam int AES256_KEY_LENGTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY_LO = 3'd1,
    ST_KEY_HI = 3'd2,
    ST_CTR    = 3'd3,
    ST_FILL   = 3'd4,
    ST_SEND   = 3'd5
  } tx_state_e;

  // A remainder of 0 means the final block is full.
  function automatic logic [15:0] keep_from_remainder(input logic [3:0] r);
    return (r == 4'd0) ? 16'hFFFF : ((16'h1 << r) - 16'h1);
  endfunction

  function automatic logic [AES_BLOCK_SIZE-1:0] keep_to_mask(input logic [15:0] keep);
    logic [AES_BLOCK_SIZE-1:0] mask;
    mask = '0;
    for (int i = 0; i < 16; i++) mask[8*i +: 8] = {8{keep[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/aes256_ctr_frame_tx.sv
// Frames one message for the AES-256 CTR engine: key halves, counter, then
// 128-bit text blocks packed from the 32-bit payload stream.
module aes256_ctr_frame_tx #(
  parameter int LEN_WIDTH  = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Cmd_valid,
  output logic                  Cmd_ready,
  input  logic [255:0]          Cmd_key,
  input  logic [127:0]          Cmd_counter,
  input  logic [LEN_WIDTH-1:0]  Cmd_length,
  input  logic                  Cmd_encrypt,
  input  logic                  S_axis_tvalid,
  output logic                  S_axis_tready,
  input  logic [WORD_WIDTH-1:0] S_axis_tdata,
  output logic                  M_axis_tvalid,
  input  logic                  M_axis_tready,
  output logic [127:0]          M_axis_tdata,
  output logic [15:0]           M_axis_tkeep,
  output logic                  M_axis_tlast,
  output logic                  M_axis_tuser,
  output logic                  Busy,
  output logic                  Done
);
  import aes_defines::*;

  // Handshakes: a beat or word moves on the rising edge where valid and ready
  // are both high; every M_axis field is a function of registers only, so it
  // holds steady while the engine stalls.

  tx_state_e               state_q, state_d;
  logic [255:0]            key_q;
  logic [127:0]            ctr_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic                    enc_q;
  logic [127:0]            blk_q;
  logic [1:0]              word_idx_q;
  logic                    done_q;

  logic [2:0]              lane_cnt;
  logic [4:0]              filled_bytes;
  logic                    last_blk;
  logic                    fill_full;
  logic [15:0]             send_keep;
  logic [LEN_WIDTH-1:0]    rem_dec;

  assign lane_cnt     = {1'b0, word_idx_q} + 3'd1;
  assign filled_bytes = {lane_cnt, 2'b00};
  assign fill_full    = (word_idx_q == 2'd3) || (rem_q <= LEN_WIDTH'(filled_bytes));
  assign last_blk     = (rem_q <= LEN_WIDTH'(16));
  // The low nibble of the remaining count equals len mod 16 on the last block.
  assign send_keep    = last_blk ? keep_from_remainder(rem_q[3:0]) : 16'hFFFF;
  assign rem_dec      = last_blk ? '0 : (rem_q - LEN_WIDTH'(16));

  always_comb begin
    state_d       = state_q;
    Cmd_ready     = 1'b0;
    S_axis_tready = 1'b0;
    M_axis_tvalid = 1'b0;
    M_axis_tdata  = '0;
    M_axis_tkeep  = '0;
    M_axis_tlast  = 1'b0;
    M_axis_tuser  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        Cmd_ready = 1'b1;
        if (Cmd_valid && (Cmd_length != '0)) state_d = ST_KEY_LO;
      end
      ST_KEY_LO: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = key_q[127:0];
        M_axis_tkeep  = 16'hFFFF;
        M_axis_tuser  = enc_q;
        if (M_axis_tready) state_d = ST_KEY_HI;
      end
      ST_KEY_HI: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = key_q[255:128];
        M_axis_tkeep  = 16'hFFFF;
        M_axis_tuser  = enc_q;
        if (M_axis_tready) state_d = ST_CTR;
      end
      ST_CTR: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = ctr_q;
        M_axis_tkeep  = 16'hFFFF;
        M_axis_tuser  = enc_q;
        if (M_axis_tready) state_d = ST_FILL;
      end
      ST_FILL: begin
        S_axis_tready = 1'b1;
        if (S_axis_tvalid && fill_full) state_d = ST_SEND;
      end
      ST_SEND: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = blk_q & keep_to_mask(send_keep);
        M_axis_tkeep  = send_keep;
        M_axis_tlast  = last_blk;
        M_axis_tuser  = enc_q;
        if (M_axis_tready) state_d = last_blk ? ST_IDLE : ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      ctr_q      <= '0;
      rem_q      <= '0;
      enc_q      <= 1'b0;
      blk_q      <= '0;
      word_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if ((state_q == ST_IDLE) && Cmd_valid) begin
        key_q      <= Cmd_key;
        ctr_q      <= Cmd_counter;
        rem_q      <= Cmd_length;
        enc_q      <= Cmd_encrypt;
        blk_q      <= '0;
        word_idx_q <= '0;
        if (Cmd_length == '0) done_q <= 1'b1;
      end
      if ((state_q == ST_FILL) && S_axis_tvalid) begin
        blk_q[WORD_WIDTH*word_idx_q +: WORD_WIDTH] <= S_axis_tdata;
        word_idx_q <= word_idx_q + 2'd1;
      end
      if ((state_q == ST_SEND) && M_axis_tready) begin
        rem_q      <= rem_dec;
        word_idx_q <= '0;
        if (last_blk) done_q <= 1'b1;
      end
    end
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = done_q;

endmodule

// File: doc/aes256_ctr_frame_tx.md
Name: aes256_ctr_frame_tx

Overview:
- Transmit-side framer that drives the slave stream port of the iterative AES-256 CTR engine.
- Takes one message command (256-bit key, 128-bit initial counter, byte length, encrypt flag) and a 32-bit payload word stream.
- Emits the engine's beat sequence: key low half, key high half, counter, then 128-bit text blocks.
- Packs payload words into blocks and generates tkeep, tlast and tuser so the engine needs no upstream glue.

Parameters:
- LEN_WIDTH, 16: width of the message byte-length field; maximum message is 2^LEN_WIDTH-1 bytes.
- WORD_WIDTH, 32: payload input word width, fixed at 32; words per block = 128/WORD_WIDTH = 4.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous, active-high reset
- Cmd_valid  in  1  command offered
- Cmd_ready  out  1  command accepted when high with Cmd_valid
- Cmd_key  in  256  AES-256 key
- Cmd_counter  in  128  initial counter block, forwarded unmodified
- Cmd_length  in  LEN_WIDTH  message length in bytes
- Cmd_encrypt  in  1  encrypt flag, forwarded on tuser
- S_axis_tvalid  in  1  payload word valid
- S_axis_tready  out  1  payload word accepted
- S_axis_tdata  in  32  payload word; byte 0 = bits [7:0]
- M_axis_tvalid  out  1  beat to engine valid
- M_axis_tready  in  1  engine ready
- M_axis_tdata  out  128  beat data
- M_axis_tkeep  out  16  byte enables
- M_axis_tlast  out  1  last text block of message
- M_axis_tuser  out  1  encrypt flag
- Busy  out  1  message in progress
- Done  out  1  one-cycle pulse, message fully sent

Behaviour:
- Reset: state IDLE; all M_axis outputs 0; S_axis_tready 0; Busy 0; Done 0; all internal registers 0. Reset mid-message abandons the frame; the engine must be reset together with this block.
- States: IDLE, KEY_LO, KEY_HI, CTR, FILL, SEND.
- IDLE: Cmd_ready=1. On handshake, latch key, counter, length and encrypt.
  - Cmd_length==0: go to IDLE, pulse Done next cycle, emit nothing.
  - Otherwise go to KEY_LO.
- KEY_LO: tvalid=1, tdata=key[127:0], tkeep=FFFF, tlast=0. Advance on tvalid&tready.
- KEY_HI: same beat with tdata=key[255:128].
- CTR: tdata=counter as latched. The engine does its own byte reversal.
- FILL: S_axis_tready=1. Each accepted word is written to block lane word_idx, i.e. tdata[32*word_idx +: 32]; word_idx is 2 bits.
  - Go to SEND after lane 3 is written, or when the bytes remaining in the message fit in the lanes filled so far.
  - Payload words needed = ceil(len/4). No extra words are consumed.
- SEND: tvalid=1, tuser=encrypt.
  - tkeep=FFFF except on the final block: (1<<r)-1 with r=len mod 16, r=0 meaning FFFF.
  - tdata bytes whose tkeep bit is 0 are forced to 0.
  - tlast=1 on the final block only.
  - On handshake, decrement the remaining byte count by min(16, remaining). If zero, go to IDLE and pulse Done; else clear word_idx and go to FILL.
- tuser=encrypt on every beat, including key and counter beats.
- tvalid, tdata, tkeep, tlast and tuser stay stable while tvalid&!tready.
- Busy=1 in every state except IDLE.
- Latency:
  - Command handshake to first KEY_LO tvalid: 1 cycle.
  - Last word of a block to SEND tvalid: 1 cycle.
  - No overlap between FILL and SEND; one block is buffered at a time.
- Commands presented while Busy are held off (Cmd_ready=0).
- The remaining-byte counter is LEN_WIDTH bits and never underflows: the decrement saturates at 0.

Decomposition:
- Shared package (aes_defines): AES_BLOCK_SIZE and AES256_KEY_LENGTH already exist. Add the state enum type and a keep_from_remainder function, which maps a 4-bit remainder to a 16-bit keep.
- No sub-module; the word packer is inline logic of about 40 lines.

Test Plan:
- len=16, words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, encrypt=1 -> 4 beats: key_lo, key_hi, ctr, block 0x0F0E..0100 with keep FFFF, tlast=1, tuser=1 on all; Done once.
- len=37 -> 10 words consumed; 3 text beats with keep FFFF, FFFF, 001F; last block bytes 5..15 = 0; tlast only on beat 3.
- len=0 -> no M_axis beats, no S_axis_tready, Done 1 cycle after command.
- Random M_axis_tready backpressure with len=48 -> beat data stable under stall; 6 beats total, order unchanged.
- Two back-to-back commands (len 20, len 5) -> Cmd_ready low while Busy; second frame starts with key_lo only after first Done; keeps 000F then 001F.
- Rst asserted during FILL of block 2 -> next cycle all outputs 0, state IDLE, Cmd_ready=1; a fresh len=16 frame then completes correctly.
